// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/forward control for a five-stage pipeline.
//   - Memory FSM (IDLE/DWAIT/DDONE) tracks one outstanding data access so a
//     completed access is not reissued while the pipe waits on instruction fetch.
//   - A shift-register scoreboard of the EX/MEM/WB destinations detects
//     read-after-write hazards for the instruction sitting in ID.
// Build option: define PIPELINE_CTRL_FORWARD_EN to enable operand forwarding
// (stall only on load-use). Undefined: stall on any pending write, fwd tied to 0.
// Debug outputs dbg_state / dbg_sb_valid / dbg_sb_load expose internal state.
module pipeline_ctrl #(
  parameter int NSTAGES = 3,
  parameter int REGW    = 5,
  parameter int FSW     = $clog2(NSTAGES)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               dreq,
  input  logic [REGW-1:0]    id_rsel1,
  input  logic [REGW-1:0]    id_rsel2,
  input  logic               id_use1,
  input  logic               id_use2,
  input  logic [REGW-1:0]    id_wsel,
  input  logic               id_wen,
  input  logic               id_load,
  input  logic               br_taken,
  output logic               en_fetch,
  output logic               en_pipe,
  output logic               flush_ifid,
  output logic               flush_idex,
  output logic [FSW-1:0]     fwd_a,
  output logic [FSW-1:0]     fwd_b,
  output logic               dmem_gate,
  output logic               ld_capture,
  output logic [1:0]         dbg_state,
  output logic [NSTAGES-1:0] dbg_sb_valid,
  output logic [NSTAGES-1:0] dbg_sb_load
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWAIT = 2'd1,
    DDONE = 2'd2
  } mem_state_t;

  // Handshake: dreq is held by the MEM stage until the pipe advances; dhit is
  // a one-cycle completion strobe from the cache. Once dhit has been seen the
  // access is complete (DDONE) and dmem_gate drops so the cache is not asked
  // again while the pipe still waits for ihit.

  mem_state_t          r_state;
  mem_state_t          w_state_nxt;

  logic                r_valid [NSTAGES];
  logic [REGW-1:0]     r_wsel  [NSTAGES];
  logic                r_load  [NSTAGES];

  logic                w_advance;
  logic                w_hazard;
  logic                w_stall;
  logic                w_flush_idex;
  logic [NSTAGES-2:0]  w_m1;
  logic [NSTAGES-2:0]  w_m2;
  logic [FSW-1:0]      w_fwd_a;
  logic [FSW-1:0]      w_fwd_b;

  // Memory FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Memory FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (dreq && !dhit)       w_state_nxt = DWAIT;
        else if (dreq && !ihit)  w_state_nxt = DDONE;
      end
      DWAIT: begin
        if (dhit && ihit)        w_state_nxt = IDLE;
        else if (dhit)           w_state_nxt = DDONE;
      end
      DDONE: begin
        if (ihit)                w_state_nxt = IDLE;
      end
      default:                   w_state_nxt = IDLE;
    endcase
  end

  // Scoreboard shifts one stage per pipeline advance; bubbles enter as invalid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < NSTAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_wsel[k]  <= '0;
        r_load[k]  <= 1'b0;
      end
    end else if (w_advance) begin
      r_valid[0] <= id_wen & ~w_flush_idex;
      r_wsel[0]  <= id_wsel;
      r_load[0]  <= id_load;
      for (int k = 1; k < NSTAGES; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_wsel[k]  <= r_wsel[k-1];
        r_load[k]  <= r_load[k-1];
      end
    end
  end

  // Source-vs-pending-destination matches; WB is excluded because the
  // register file is written before it is read in the same cycle.
  always_comb begin
    w_m1 = '0;
    w_m2 = '0;
    for (int k = 0; k < NSTAGES-1; k++) begin
      w_m1[k] = id_use1 && (id_rsel1 != '0) && r_valid[k] && (r_wsel[k] == id_rsel1);
      w_m2[k] = id_use2 && (id_rsel2 != '0) && r_valid[k] && (r_wsel[k] == id_rsel2);
    end
  end

`ifdef PIPELINE_CTRL_FORWARD_EN
  // Forwarding: pick the youngest matching stage; only a load still in EX stalls.
  always_comb begin
    w_fwd_a  = '0;
    w_fwd_b  = '0;
    for (int k = NSTAGES-2; k >= 0; k--) begin
      if (w_m1[k]) w_fwd_a = FSW'(k + 1);
      if (w_m2[k]) w_fwd_b = FSW'(k + 1);
    end
    w_hazard = (w_m1[0] | w_m2[0]) & r_load[0];
  end
`else
  // No forwarding: any pending write to a source register stalls ID.
  always_comb begin
    w_fwd_a  = '0;
    w_fwd_b  = '0;
    w_hazard = (|w_m1) | (|w_m2);
  end
`endif

  // Pipeline enables and bubble insertion; a taken branch overrides a stall.
  always_comb begin
    w_advance    = ihit & (~dreq | dhit | (r_state == DDONE));
    w_stall      = w_hazard & ~br_taken;
    w_flush_idex = w_advance & (w_stall | br_taken);
    en_pipe      = w_advance;
    en_fetch     = w_advance & ~w_stall;
    flush_ifid   = w_advance & br_taken;
    flush_idex   = w_flush_idex;
    fwd_a        = w_fwd_a;
    fwd_b        = w_fwd_b;
    dmem_gate    = (r_state != DDONE);
    ld_capture   = dhit & dreq & (r_state != DDONE);
  end

  // Debug view of FSM and scoreboard.
  always_comb begin
    dbg_state = r_state;
    for (int k = 0; k < NSTAGES; k++) begin
      dbg_sb_valid[k] = r_valid[k];
      dbg_sb_load[k]  = r_load[k];
    end
  end

endmodule
